// File: rtl/store_commit_buffer.sv
// In-order store buffer between ROB commit and the data-memory write port.
// Also forwards buffered store data to loads and stalls loads on partial overlap.
module store_commit_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_addr,
    input  logic [31:0] commit_data,
    input  logic [2:0]  commit_width,
    output logic        commit_ready,
    output logic        misalign_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_width,
    output logic        ld_fwd_hit,
    output logic [31:0] ld_fwd_data,
    output logic        ld_stall,
    output logic        empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             misalign_q, misalign_d;
    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];

    logic full, accept, legal, push, pop;
    logic [3:0]  cmt_strb, lmask, sel_strb;
    logic [31:0] cmt_wdata, sel_data;
    logic        found;
    logic [PTR_W-1:0] idx;
    logic        unused_ld_sign;

    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign unused_ld_sign = ld_width[2];

    assign full         = (count_q == CNT_W'(DEPTH));
    assign commit_ready = !full;
    assign empty        = (count_q == '0);
    assign mem_req      = !empty;
    assign mem_addr     = {entry_q[head_q].waddr, 2'b00};
    assign mem_wdata    = entry_q[head_q].wdata;
    assign mem_wstrb    = entry_q[head_q].strb;
    assign misalign_err = misalign_q;

    // Commit decode: legality, lane strobe and lane-replicated data.
    always_comb begin
        legal     = 1'b0;
        cmt_wdata = commit_data;
        case (commit_width)
            3'b000: begin legal = 1'b1;                      cmt_wdata = {4{commit_data[7:0]}};  end
            3'b001: begin legal = !commit_addr[0];           cmt_wdata = {2{commit_data[15:0]}}; end
            3'b010: begin legal = (commit_addr[1:0] == 2'b00); cmt_wdata = commit_data;          end
            default: legal = 1'b0;
        endcase
        cmt_strb = lane_mask(commit_width[1:0], commit_addr[1:0]);
        accept   = commit_valid && !full;
        push     = accept && legal;
        pop      = mem_req && mem_ack;
    end

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        entry_d    = entry_q;
        misalign_d = accept && !legal;
        if (push) begin
            entry_d[tail_q] = '{waddr: commit_addr[31:2], wdata: cmt_wdata, strb: cmt_strb};
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    // Forwarding: scan oldest to youngest so the last match is the youngest.
    always_comb begin
        lmask    = lane_mask(ld_width[1:0], ld_addr[1:0]);
        found    = 1'b0;
        sel_strb = '0;
        sel_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (entry_q[idx].waddr == ld_addr[31:2]) &&
                ((entry_q[idx].strb & lmask) != 4'b0000)) begin
                found    = 1'b1;
                sel_strb = entry_q[idx].strb;
                sel_data = entry_q[idx].wdata;
            end
        end
        ld_fwd_hit  = ld_valid && found && ((sel_strb & lmask) == lmask);
        ld_stall    = ld_valid && found && ((sel_strb & lmask) != lmask);
        ld_fwd_data = ld_fwd_hit ? sel_data : 32'h0;
    end

endmodule
